// File: rtl/ptltx_pkg.sv
// rtl/ptltx_pkg.sv - shared types and helpers for the PTL transmitter array
package ptltx_pkg;

    typedef enum logic [1:0] {IDLE, WINDOW, POISONED} ch_state_e;

    // Smallest width (at least 1) able to hold n-1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 64; i++) s += 32'(v[i]);
        return s;
    endfunction

endpackage

// File: rtl/ptltx_channel.sv
// rtl/ptltx_channel.sv - one transmitter channel: edge detect, delay line, timing window, poison
module ptltx_channel
    import ptltx_pkg::*;
#(
    parameter int DELAY_CYC = 3,
    parameter int CT_CYC    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic en,
    input  logic ready,
    output logic q,
    output logic busy,
    output logic viol,
    output logic viol_pulse,
    output logic viol_evt
);

    localparam int CW = clog2(CT_CYC);
    localparam int LW = (DELAY_CYC > 1) ? DELAY_CYC - 1 : 1;

    logic          a_d_q;
    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic          q_q, q_d;
    logic          viol_pulse_q, viol_pulse_d;
    logic          pulse, qual, sched, tap;

    always_comb begin
        pulse    = a ^ a_d_q;
        qual     = pulse & en & ready & (state_q != POISONED);
        viol_evt = qual & (state_q == WINDOW);
        sched    = qual & (state_q == IDLE);
        // With a one-cycle delay the toggle bypasses the line entirely.
        tap      = (DELAY_CYC == 1) ? sched : line_q[LW-1];

        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q << 1;
        line_d[0]    = sched;
        q_d          = q_q ^ tap;
        viol_pulse_d = viol_evt;

        case (state_q)
            IDLE: begin
                if (sched) begin
                    cnt_d = CW'(CT_CYC - 1);
                    if (CT_CYC > 1) state_d = WINDOW;
                end
            end
            WINDOW: begin
                if (viol_evt) begin
                    state_d = POISONED;
                    cnt_d   = '0;
                    line_d  = '0;
                    q_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = IDLE;
                end
            end
            default: begin
                cnt_d  = '0;
                line_d = '0;
                q_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        a_d_q <= a;
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            q_q          <= 1'b0;
            viol_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            q_q          <= q_d;
            viol_pulse_q <= viol_pulse_d;
        end
    end

    assign q          = q_q;
    assign busy       = (cnt_q != '0);
    assign viol       = (state_q == POISONED);
    assign viol_pulse = viol_pulse_q;

endmodule

// File: rtl/ptltx_array.sv
// rtl/ptltx_array.sv - multi-channel PTL transmitter with warm-up and violation counting
module ptltx_array
    import ptltx_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DELAY_CYC   = 3,
    parameter int CT_CYC      = 7,
    parameter int STARTUP_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] viol,
    output logic [CHANNELS-1:0] viol_pulse,
    output logic [CNT_W-1:0]    viol_count,
    output logic                ready
);

    localparam int          SW   = clog2(STARTUP_CYC);
    localparam int unsigned CMAX = (32'd1 << CNT_W) - 32'd1;

    logic [SW-1:0]       wc_q, wc_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] viol_evt;
    int unsigned         cnt_sum;

    always_comb begin
        wc_d    = ready_q ? wc_q : wc_q + SW'(1);
        ready_d = ready_q | (wc_q == SW'(STARTUP_CYC - 1));
        cnt_sum = 32'(cnt_q) + popcount(64'(viol_evt));
        cnt_d   = (cnt_sum > CMAX) ? CNT_W'(CMAX) : CNT_W'(cnt_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q    <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wc_q    <= wc_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // A zero warm-up means edges count from the very first cycle out of reset.
    assign ready      = (STARTUP_CYC == 0) ? !rst : ready_q;
    assign viol_count = cnt_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ptltx_channel #(
            .DELAY_CYC(DELAY_CYC),
            .CT_CYC   (CT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .a         (a[i]),
            .en        (en[i]),
            .ready     (ready),
            .q         (q[i]),
            .busy      (busy[i]),
            .viol      (viol[i]),
            .viol_pulse(viol_pulse[i]),
            .viol_evt  (viol_evt[i])
        );
    end

endmodule

// File: tb/tb_ptltx_array.sv
// tb/tb_ptltx_array.sv - randomized scoreboard bench for ptltx_array in two configurations
module tb_ptltx_array;

    localparam int CH = 4;
    localparam int SU = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] a   = '0;
    logic [CH-1:0] en  = '1;

    logic [CH-1:0] q0, b0, v0, p0, q1, b1, v1, p1;
    logic [7:0]    c0;
    logic [1:0]    c1;
    logic          r0, r1;

    ptltx_array dut_a (
        .clk(clk), .rst(rst), .a(a), .en(en),
        .q(q0), .busy(b0), .viol(v0), .viol_pulse(p0), .viol_count(c0), .ready(r0)
    );

    ptltx_array #(.CHANNELS(CH), .DELAY_CYC(8), .CT_CYC(3), .STARTUP_CYC(SU), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .a(a), .en(en),
        .q(q1), .busy(b1), .viol(v1), .viol_pulse(p1), .viol_count(c1), .ready(r1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic [31:0]   cyc;
        logic [CH-1:0] q0, b0, v0, p0, q1, b1, v1, p1;
        logic [7:0]    c0;
        logic [1:0]    c1;
        logic          rdy;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks   = 0;
    int   failures = 0;
    int   cycno    = 0;

    // Reference model: absolute cycle bookkeeping per configuration and channel.
    bit            pois[2][CH];
    int            vcyc[2][CH];
    bit            hl[2][CH];
    int            last[2][CH];
    bit            pend[2][CH][16];
    bit            qm[2][CH];
    int            cnt[2];
    int            tcur = 0;
    logic [CH-1:0] prev_a = '0;
    bit            rst_seen = 1'b0;

    function automatic int dly(input int k);  return (k == 0) ? 3 : 8;   endfunction
    function automatic int ctw(input int k);  return (k == 0) ? 7 : 3;   endfunction
    function automatic int cmax(input int k); return (k == 0) ? 255 : 3; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            for (int c = 0; c < CH; c++) begin
                pois[k][c] = 0; vcyc[k][c] = -1; hl[k][c] = 0; last[k][c] = 0; qm[k][c] = 0;
                for (int s = 0; s < 16; s++) pend[k][c][s] = 0;
            end
        end
        tcur = 0;
    endtask

    task automatic step(input logic r, input logic [CH-1:0] ai, input logic [CH-1:0] ei);
        exp_t          e;
        logic [CH-1:0] qv[2], bv[2], vv[2], pv[2];
        int            nv, dt;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (pend[k][c][tcur % 16]) begin
                    pend[k][c][tcur % 16] = 0;
                    qm[k][c] = ~qm[k][c];
                end
                dt       = tcur - last[k][c];
                qv[k][c] = qm[k][c];
                bv[k][c] = !pois[k][c] && hl[k][c] && dt >= 1 && dt <= ctw(k) - 1;
                vv[k][c] = pois[k][c];
                pv[k][c] = pois[k][c] && (vcyc[k][c] == tcur);
            end
        end
        e.vld = rst_seen; e.cyc = 32'(cycno); e.rdy = (tcur >= SU);
        e.q0 = qv[0]; e.b0 = bv[0]; e.v0 = vv[0]; e.p0 = pv[0]; e.c0 = 8'(cnt[0]);
        e.q1 = qv[1]; e.b1 = bv[1]; e.v1 = vv[1]; e.p1 = pv[1]; e.c1 = 2'(cnt[1]);
        sb.push_back(e);

        if (r) begin
            rst_seen = 1'b1;
            model_reset();
        end else if (rst_seen) begin
            for (int k = 0; k < 2; k++) begin
                nv = 0;
                for (int c = 0; c < CH; c++) begin
                    if ((ai[c] ^ prev_a[c]) && ei[c] && tcur >= SU && !pois[k][c]) begin
                        if (hl[k][c] && tcur - last[k][c] < ctw(k)) begin
                            pois[k][c] = 1; vcyc[k][c] = tcur + 1; qm[k][c] = 0; nv++;
                            for (int s = 0; s < 16; s++) pend[k][c][s] = 0;
                        end else begin
                            hl[k][c] = 1; last[k][c] = tcur;
                            pend[k][c][(tcur + dly(k)) % 16] = 1;
                        end
                    end
                end
                cnt[k] = (cnt[k] + nv > cmax(k)) ? cmax(k) : cnt[k] + nv;
            end
            tcur++;
        end
        prev_a = ai;
    endtask

    task automatic drive(input logic r, input logic [CH-1:0] ai, input logic [CH-1:0] ei);
        @(posedge clk);
        #1;
        rst = r; a = ai; en = ei;
        cycno++;
        step(r, ai, ei);
    endtask

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.vld) begin
                chk("q_a",     me.cyc, 32'(q0), 32'(me.q0));
                chk("busy_a",  me.cyc, 32'(b0), 32'(me.b0));
                chk("viol_a",  me.cyc, 32'(v0), 32'(me.v0));
                chk("vpulse_a", me.cyc, 32'(p0), 32'(me.p0));
                chk("count_a", me.cyc, 32'(c0), 32'(me.c0));
                chk("ready_a", me.cyc, 32'(r0), 32'(me.rdy));
                chk("q_b",     me.cyc, 32'(q1), 32'(me.q1));
                chk("busy_b",  me.cyc, 32'(b1), 32'(me.b1));
                chk("viol_b",  me.cyc, 32'(v1), 32'(me.v1));
                chk("vpulse_b", me.cyc, 32'(p1), 32'(me.p1));
                chk("count_b", me.cyc, 32'(c1), 32'(me.c1));
                chk("ready_b", me.cyc, 32'(r1), 32'(me.rdy));
            end
        end
    end

    initial begin
        logic [CH-1:0] na, ne;
        int            den, len;
        model_reset();
        for (int ep = 0; ep < 14; ep++) begin
            na = a ^ CH'($urandom_range(0, 15));
            for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++) drive(1'b1, na, '1);
            den = (ep % 3 == 0) ? 12 : (ep % 3 == 1) ? 5 : 20;
            len = 40 + int'($urandom_range(0, 60));
            for (int i = 0; i < len; i++) begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, den - 1) == 0) na[c] = ~na[c];
                    ne[c] = ($urandom_range(0, 7) != 0);
                end
                drive(1'b0, na, ne);
            end
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", cycno, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
